// File: rtl/rob_pkg.sv
// Shared ROB parameters, entry-kind encoding and per-entry payload layout.
package rob_pkg;
   localparam int ROB_R    = 4;
   localparam int ROB_SIZE = 1 << ROB_R;

   localparam logic [ROB_R:0] ROB_CAP     = (ROB_R + 1)'(ROB_SIZE);
   localparam logic [ROB_R:0] ROB_FULL_AT = (ROB_R + 1)'(ROB_SIZE - 1);

   typedef enum logic [1:0] {
      KIND_REG    = 2'd0,
      KIND_BRANCH = 2'd1,
      KIND_STORE  = 2'd2,
      KIND_HALT   = 2'd3
   } kind_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alt_pc;
      logic [31:0] value;
      logic [4:0]  rd;
      logic [1:0]  kind;
      logic        pred_taken;
   } entry_t;
endpackage

// File: rtl/rob.sv
// 16-entry reorder buffer: in-order allocate, out-of-order writeback, in-order
// commit, branch-mispredict flush and sticky halt.
module rob
   import rob_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             is_dc,
   input  logic [31:0]      dc_pc,
   input  logic [1:0]       dc_kind,
   input  logic [4:0]       dc_rd,
   input  logic             dc_pred_taken,
   input  logic [31:0]      dc_alt_pc,
   output logic [ROB_R-1:0] rob_tail,
   output logic             rob_full,
   input  logic             is_rs,
   input  logic [ROB_R-1:0] rs_rob_id,
   input  logic [31:0]      rs_value,
   input  logic             is_lsb,
   input  logic [ROB_R-1:0] lsb_rob_id,
   input  logic [31:0]      lsb_res,
   input  logic [ROB_R-1:0] qry1_id,
   input  logic [ROB_R-1:0] qry2_id,
   output logic             qry1_rdy,
   output logic             qry2_rdy,
   output logic [31:0]      qry1_val,
   output logic [31:0]      qry2_val,
   output logic             commit_valid,
   output logic [1:0]       commit_kind,
   output logic [4:0]       commit_rd,
   output logic [31:0]      commit_value,
   output logic [ROB_R-1:0] commit_rob_id,
   output logic [31:0]      commit_pc,
   output logic             rob_clear,
   output logic [31:0]      clear_pc,
   output logic             halt
);
   entry_t              ent [ROB_SIZE];
   logic [ROB_SIZE-1:0] busy;
   logic [ROB_SIZE-1:0] ready;
   logic [ROB_R-1:0]    head;
   logic [ROB_R-1:0]    tail;
   logic [ROB_R:0]      count;
   logic                commit_valid_q;
   logic                rob_clear_q;
   entry_t              head_ent;
   logic                live;
   logic                do_alloc;
   logic                do_commit;
   logic                mispredict;
   logic                wb_rs;
   logic                wb_lsb;

   // A pending flush swallows every request seen in its cycle.
   assign live       = rdy_in && !rob_clear_q;
   assign head_ent   = ent[head];
   assign do_alloc   = live && is_dc && (count != ROB_CAP);
   assign do_commit  = live && !halt && busy[head] && ready[head];
   assign mispredict = (head_ent.kind == KIND_BRANCH) &&
                       (head_ent.value[0] != head_ent.pred_taken);
   assign wb_rs      = live && is_rs && busy[rs_rob_id];
   assign wb_lsb     = live && is_lsb && busy[lsb_rob_id];

   assign rob_tail     = tail;
   assign rob_full     = (count >= ROB_FULL_AT);
   assign commit_valid = commit_valid_q && rdy_in;
   assign rob_clear    = rob_clear_q && rdy_in;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy           <= '0;
         ready          <= '0;
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         commit_valid_q <= 1'b0;
         rob_clear_q    <= 1'b0;
         commit_kind    <= '0;
         commit_rd      <= '0;
         commit_value   <= '0;
         commit_rob_id  <= '0;
         commit_pc      <= '0;
         clear_pc       <= '0;
         halt           <= 1'b0;
      end else if (rdy_in) begin
         if (rob_clear_q) begin
            busy           <= '0;
            ready          <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            commit_valid_q <= 1'b0;
            rob_clear_q    <= 1'b0;
         end else begin
            commit_valid_q <= do_commit;
            rob_clear_q    <= do_commit && mispredict;
            if (do_commit) begin
               commit_kind   <= head_ent.kind;
               commit_rd     <= head_ent.rd;
               commit_value  <= head_ent.value;
               commit_rob_id <= head;
               commit_pc     <= head_ent.pc;
               if (mispredict) clear_pc <= head_ent.alt_pc;
               if (head_ent.kind == KIND_HALT) halt <= 1'b1;
            end
            if (do_alloc) begin
               busy[tail]  <= 1'b1;
               ready[tail] <= (dc_kind == KIND_HALT);
               tail        <= tail + 4'd1;
            end
            if (wb_lsb) ready[lsb_rob_id] <= 1'b1;
            if (wb_rs) ready[rs_rob_id] <= 1'b1;
            if (do_commit) begin
               busy[head] <= 1'b0;
               head       <= head + 4'd1;
            end
            unique case ({do_alloc, do_commit})
               2'b10:   count <= count + 5'd1;
               2'b01:   count <= count - 5'd1;
               default: ;
            endcase
         end
      end
   end

   // Payload carries no reset; busy/ready gate every use of it.
   always_ff @(posedge clk_in) begin
      if (do_alloc) begin
         ent[tail].pc         <= dc_pc;
         ent[tail].alt_pc     <= dc_alt_pc;
         ent[tail].rd         <= dc_rd;
         ent[tail].kind       <= dc_kind;
         ent[tail].pred_taken <= dc_pred_taken;
      end
      if (wb_lsb) ent[lsb_rob_id].value <= lsb_res;
      if (wb_rs) ent[rs_rob_id].value <= rs_value;
   end

   // Bus bypass overrides stored state; the ALU bus wins over the LSB bus.
   always_comb begin
      qry1_rdy = busy[qry1_id] && ready[qry1_id];
      qry1_val = ent[qry1_id].value;
      qry2_rdy = busy[qry2_id] && ready[qry2_id];
      qry2_val = ent[qry2_id].value;
      if (is_lsb && (lsb_rob_id == qry1_id)) begin
         qry1_rdy = 1'b1;
         qry1_val = lsb_res;
      end
      if (is_rs && (rs_rob_id == qry1_id)) begin
         qry1_rdy = 1'b1;
         qry1_val = rs_value;
      end
      if (is_lsb && (lsb_rob_id == qry2_id)) begin
         qry2_rdy = 1'b1;
         qry2_val = lsb_res;
      end
      if (is_rs && (rs_rob_id == qry2_id)) begin
         qry2_rdy = 1'b1;
         qry2_val = rs_value;
      end
   end
endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed scenarios plus randomized traffic, all checked
// against a program-order queue model of the reorder buffer.
module tb_rob;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in;
   logic        is_dc;
   logic [31:0] dc_pc;
   logic [1:0]  dc_kind;
   logic [4:0]  dc_rd;
   logic        dc_pred_taken;
   logic [31:0] dc_alt_pc;
   logic [3:0]  rob_tail;
   logic        rob_full;
   logic        is_rs;
   logic [3:0]  rs_rob_id;
   logic [31:0] rs_value;
   logic        is_lsb;
   logic [3:0]  lsb_rob_id;
   logic [31:0] lsb_res;
   logic [3:0]  qry1_id = 4'd0;
   logic [3:0]  qry2_id = 4'd0;
   logic        qry1_rdy, qry2_rdy;
   logic [31:0] qry1_val, qry2_val;
   logic        commit_valid;
   logic [1:0]  commit_kind;
   logic [4:0]  commit_rd;
   logic [31:0] commit_value;
   logic [3:0]  commit_rob_id;
   logic [31:0] commit_pc;
   logic        rob_clear;
   logic [31:0] clear_pc;
   logic        halt;

   int n_checks = 0;
   int n_errors = 0;

   rob dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .is_dc(is_dc), .dc_pc(dc_pc), .dc_kind(dc_kind), .dc_rd(dc_rd),
      .dc_pred_taken(dc_pred_taken), .dc_alt_pc(dc_alt_pc),
      .rob_tail(rob_tail), .rob_full(rob_full),
      .is_rs(is_rs), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
      .is_lsb(is_lsb), .lsb_rob_id(lsb_rob_id), .lsb_res(lsb_res),
      .qry1_id(qry1_id), .qry2_id(qry2_id),
      .qry1_rdy(qry1_rdy), .qry2_rdy(qry2_rdy),
      .qry1_val(qry1_val), .qry2_val(qry2_val),
      .commit_valid(commit_valid), .commit_kind(commit_kind),
      .commit_rd(commit_rd), .commit_value(commit_value),
      .commit_rob_id(commit_rob_id), .commit_pc(commit_pc),
      .rob_clear(rob_clear), .clear_pc(clear_pc), .halt(halt)
   );

   // ---------------- clock ----------------
   always #5 clk_in = ~clk_in;

   // ---------------- reference model ----------------
   logic [3:0]  exp_q[$];          // live ids in program order (head first)
   logic [1:0]  m_kind [16];
   logic [4:0]  m_rd   [16];
   logic        m_pred [16];
   logic [31:0] m_alt  [16];
   logic [31:0] m_pc   [16];
   logic [31:0] m_val  [16];
   logic        m_rdy  [16];
   int          m_tail;
   logic        m_cv, m_clear, m_halt;
   logic [1:0]  m_ckind;
   logic [4:0]  m_crd;
   logic [31:0] m_cval, m_cpc, m_clear_pc;
   logic [3:0]  m_cid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_q(input logic [3:0] id);
      foreach (exp_q[i]) if (exp_q[i] == id) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] pick_id();
      if (exp_q.size() > 0 && $urandom_range(0, 3) != 0)
         return exp_q[$urandom_range(0, exp_q.size() - 1)];
      return 4'($urandom_range(0, 15));
   endfunction

   task automatic exp_qry(input logic [3:0] id, output logic r, output logic [31:0] v);
      r = in_q(id) && m_rdy[id];
      v = m_val[id];
      if (is_lsb && lsb_rob_id == id) begin r = 1'b1; v = lsb_res; end
      if (is_rs && rs_rob_id == id) begin r = 1'b1; v = rs_value; end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_tail = 0; m_cv = 0; m_clear = 0; m_halt = 0;
      m_ckind = '0; m_crd = '0; m_cval = '0; m_cpc = '0; m_cid = '0; m_clear_pc = '0;
   endtask

   task automatic model_update();
      int pre_size;
      bit commit;
      logic [3:0] hid;
      if (!rdy_in) return;
      if (m_clear) begin
         exp_q.delete();
         m_tail = 0; m_cv = 0; m_clear = 0;
         return;
      end
      pre_size = exp_q.size();
      commit = !m_halt && pre_size > 0 && m_rdy[exp_q[0]];
      m_cv = commit;
      m_clear = 0;
      if (commit) begin
         hid = exp_q[0];
         m_ckind = m_kind[hid]; m_crd = m_rd[hid]; m_cval = m_val[hid];
         m_cid = hid; m_cpc = m_pc[hid];
         if (m_kind[hid] == 2'd1 && m_val[hid][0] != m_pred[hid]) begin
            m_clear = 1; m_clear_pc = m_alt[hid];
         end
         if (m_kind[hid] == 2'd3) m_halt = 1;
      end
      if (is_lsb && in_q(lsb_rob_id)) begin m_rdy[lsb_rob_id] = 1; m_val[lsb_rob_id] = lsb_res; end
      if (is_rs && in_q(rs_rob_id)) begin m_rdy[rs_rob_id] = 1; m_val[rs_rob_id] = rs_value; end
      if (commit) void'(exp_q.pop_front());
      if (is_dc && pre_size < 16) begin
         hid = 4'(m_tail);
         exp_q.push_back(hid);
         m_kind[hid] = dc_kind; m_rd[hid] = dc_rd; m_pred[hid] = dc_pred_taken;
         m_alt[hid] = dc_alt_pc; m_pc[hid] = dc_pc;
         m_rdy[hid] = (dc_kind == 2'd3);
         m_tail = (m_tail + 1) % 16;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      rdy_in = 1'b1; is_dc = 1'b0; is_rs = 1'b0; is_lsb = 1'b0;
      dc_pc = '0; dc_kind = '0; dc_rd = '0; dc_pred_taken = 1'b0; dc_alt_pc = '0;
      rs_rob_id = '0; rs_value = '0; lsb_rob_id = '0; lsb_res = '0;
   endtask

   task automatic drive_dc(input logic [1:0] k, input logic [4:0] rd, input logic p, input logic [31:0] alt);
      is_dc = 1'b1; dc_kind = k; dc_rd = rd; dc_pred_taken = p; dc_alt_pc = alt; dc_pc = $urandom;
   endtask

   task automatic drive_rs(input logic [3:0] id, input logic [31:0] v);
      is_rs = 1'b1; rs_rob_id = id; rs_value = v;
   endtask

   task automatic drive_lsb(input logic [3:0] id, input logic [31:0] v);
      is_lsb = 1'b1; lsb_rob_id = id; lsb_res = v;
   endtask

   // Compare all outputs against the model, advance one clock, clear strobes.
   task automatic step();
      logic r;
      logic [31:0] v;
      #1;
      check("rob_tail", 32'(rob_tail), 32'(m_tail));
      check("rob_full", 32'(rob_full), 32'(exp_q.size() >= 15));
      check("commit_valid", 32'(commit_valid), 32'(m_cv && rdy_in));
      check("rob_clear", 32'(rob_clear), 32'(m_clear && rdy_in));
      check("halt", 32'(halt), 32'(m_halt));
      if (m_cv && rdy_in) begin
         check("commit_kind", 32'(commit_kind), 32'(m_ckind));
         check("commit_rd", 32'(commit_rd), 32'(m_crd));
         check("commit_value", commit_value, m_cval);
         check("commit_rob_id", 32'(commit_rob_id), 32'(m_cid));
         check("commit_pc", commit_pc, m_cpc);
      end
      if (m_clear && rdy_in) check("clear_pc", clear_pc, m_clear_pc);
      exp_qry(qry1_id, r, v);
      check("qry1_rdy", 32'(qry1_rdy), 32'(r));
      if (r) check("qry1_val", qry1_val, v);
      exp_qry(qry2_id, r, v);
      check("qry2_rdy", 32'(qry2_rdy), 32'(r));
      if (r) check("qry2_val", qry2_val, v);
      model_update();
      @(posedge clk_in);
      @(negedge clk_in);
      idle();
   endtask

   // Asynchronous reset between edges; outputs must drop with no clock.
   task automatic do_reset();
      idle();
      #2 rst_in = 1'b0;
      #1;
      check("rst_commit_valid", 32'(commit_valid), 0);
      check("rst_rob_clear", 32'(rob_clear), 0);
      check("rst_clear_pc", clear_pc, 0);
      check("rst_halt", 32'(halt), 0);
      check("rst_rob_tail", 32'(rob_tail), 0);
      check("rst_rob_full", 32'(rob_full), 0);
      check("rst_commit_rob_id", 32'(commit_rob_id), 0);
      check("rst_commit_value", commit_value, 0);
      model_reset();
      @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int id1_commits;
      foreach (m_val[i]) begin m_val[i] = '0; m_rdy[i] = 1'b0; end
      idle();
      do_reset();
      step();

      // In-order commit after out-of-order writeback.
      for (int i = 1; i <= 3; i++) begin drive_dc(2'd0, 5'(i), 1'b0, 32'h0); step(); end
      drive_rs(4'd2, 32'h22); step();
      drive_rs(4'd1, 32'h11); step();
      drive_rs(4'd0, 32'h10); step();
      for (int i = 0; i < 4; i++) step();

      // Fill to 16, wrap, overfill attempt, drain in order.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive_dc(2'(i % 3), 5'(i), 1'b0, 32'h0);
         step();
         if (i == 14) check("full_at_15", 32'(rob_full), 1);
      end
      check("tail_wrap", 32'(rob_tail), 0);
      drive_dc(2'd0, 5'd31, 1'b0, 32'h0); step();
      for (int i = 15; i >= 0; i--) begin drive_lsb(4'(i), 32'(i * 3)); step(); end
      for (int i = 0; i < 20; i++) step();

      // Mispredicted branch flushes; correct one does not.
      do_reset();
      drive_dc(2'd1, 5'd0, 1'b0, 32'h100); step();
      drive_rs(4'd0, 32'h1); step();
      n = 0;
      while (!rob_clear && n < 6) begin step(); n++; end
      check("clr_seen", 32'(rob_clear), 1);
      check("clr_pc", clear_pc, 32'h100);
      drive_dc(2'd0, 5'd4, 1'b0, 32'h0); step();
      check("after_clr_tail", 32'(rob_tail), 0);
      check("after_clr_clear", 32'(rob_clear), 0);
      drive_dc(2'd1, 5'd0, 1'b1, 32'h200); step();
      drive_rs(4'd0, 32'h1); step();
      for (int i = 0; i < 3; i++) step();

      // Same-cycle bypass on both buses.
      do_reset();
      for (int i = 0; i < 8; i++) begin drive_dc(2'd0, 5'(i + 1), 1'b0, 32'h0); step(); end
      qry1_id = 4'd5; qry2_id = 4'd6;
      drive_rs(4'd5, 32'hAA); drive_lsb(4'd6, 32'hBB);
      #1;
      check("byp_q1_rdy", 32'(qry1_rdy), 1);
      check("byp_q1_val", qry1_val, 32'hAA);
      check("byp_q2_rdy", 32'(qry2_rdy), 1);
      check("byp_q2_val", qry2_val, 32'hBB);
      step();
      step();

      // Mid-stream reset with a commit pulse on the outputs.
      drive_rs(4'd0, 32'h55); step();
      step();
      check("pre_rst_cv", 32'(commit_valid), 1);
      do_reset();
      step();

      // Halt is sticky and blocks younger ready entries.
      qry1_id = 4'd1; qry2_id = 4'd1;
      drive_dc(2'd3, 5'd0, 1'b0, 32'h0); step();
      drive_dc(2'd0, 5'd5, 1'b0, 32'h0); step();
      drive_rs(4'd1, 32'h77); step();
      id1_commits = 0;
      for (int i = 0; i < 6; i++) begin
         if (commit_valid && commit_rob_id == 4'd1) id1_commits++;
         step();
      end
      check("halt_sticky", 32'(halt), 1);
      check("no_commit_after_halt", 32'(id1_commits), 0);

      // Randomized traffic including ready stalls and mispredicts.
      do_reset();
      for (int c = 0; c < 800; c++) begin
         int k;
         rdy_in = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, 7);
            drive_dc((k < 5) ? 2'd0 : (k == 5) ? 2'd1 : 2'd2, 5'($urandom), 1'($urandom), $urandom);
         end
         if ($urandom_range(0, 2) != 0) drive_rs(pick_id(), $urandom);
         if ($urandom_range(0, 2) == 0) drive_lsb(pick_id(), $urandom);
         qry1_id = pick_id();
         qry2_id = 4'($urandom_range(0, 15));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
